// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // FETCH must encode as zero so an uninitialised state register idles safely
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, otherwise holds.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [ILEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            valid_in,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr <= NOP;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, hold buffer, IF/ID register.
// Optional IF_PERF_COUNTERS_EN adds saturating fetch/drop counters.
//
//   state   | meaning
//   FETCH   | issue request for PC_F this cycle
//   WAIT    | request outstanding, response will be used
//   HOLD    | response captured in hold buffer, decode stalled
//   DROP    | stale request outstanding, response will be discarded
module if_stage
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter logic [XLEN-1:0] HANDLER_PC = 64'h0000_0000_0000_1000,
  parameter logic [ILEN-1:0] NOP_INSTR  = if_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_D,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_to_handler,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC_F,
  output logic [ILEN-1:0] instruction_D,
  output logic [XLEN-1:0] PC_D,
  output logic            valid_D
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     drop_count
`endif
);

  state_t          state;
  logic [XLEN-1:0] pc_f;
  logic [ILEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            hold_valid;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            in_flight;

  logic            ifid_load;
  logic            ifid_flush;
  logic [ILEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pc;
  logic            ifid_valid;

  assign redirect  = jump_to_handler | branch_taken;
  assign target    = jump_to_handler ? HANDLER_PC : branch_target;
  assign in_flight = ((state == S_WAIT) || (state == S_DROP)) && !imem_rvalid;

  // A redirect in FETCH suppresses the request so no stale fetch is ever issued
  assign imem_req  = (state == S_FETCH) && !reset && !redirect;
  assign imem_addr = pc_f;
  assign PC_F      = pc_f;

  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = imem_rdata;
    ifid_pc    = pc_f;
    ifid_valid = 1'b1;
    if (reset) begin
      ifid_flush = 1'b0;
    end else if (redirect) begin
      ifid_flush = 1'b1;
    end else if ((state == S_WAIT) && imem_rvalid && !stall_D) begin
      ifid_load = 1'b1;
    end else if ((state == S_HOLD) && !stall_D) begin
      ifid_load  = 1'b1;
      ifid_instr = hold_instr;
      ifid_pc    = hold_pc;
      ifid_valid = hold_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f       <= RESET_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_valid <= 1'b0;
      if (in_flight) state <= S_DROP;
      else           state <= S_FETCH;
    end else if (redirect) begin
      pc_f       <= target;
      hold_valid <= 1'b0;
      // Any request still in flight (WAIT or DROP) must be drained before refetching
      if (in_flight) state <= S_DROP;
      else           state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            pc_f <= pc_f + 64'd4;
            if (stall_D) begin
              hold_instr <= imem_rdata;
              hold_pc    <= pc_f;
              hold_valid <= 1'b1;
              state      <= S_HOLD;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (!stall_D) begin
            hold_valid <= 1'b0;
            state      <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (ifid_instr),
    .pc_in    (ifid_pc),
    .valid_in (ifid_valid),
    .instr    (instruction_D),
    .pc       (PC_D),
    .valid    (valid_D)
  );

`ifdef IF_PERF_COUNTERS_EN
  logic dropped;

  assign dropped = !reset && imem_rvalid &&
                   ((state == S_DROP) || (redirect && (state == S_WAIT)));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      drop_count  <= '0;
    end else begin
      if (ifid_load && (fetch_count != '1)) fetch_count <= fetch_count + 32'd1;
      if (dropped && (drop_count != '1))    drop_count  <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized traffic
// against a flag-based reference model and a variable-latency memory.
module tb_if_stage;

  localparam logic [63:0] HPC = 64'h0000_0000_0000_1000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall_D, branch_taken, jump_to_handler, imem_rvalid;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr, PC_F, PC_D;
  logic [31:0] imem_rdata, instruction_D;
  logic        valid_D;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_D         (stall_D),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump_to_handler (jump_to_handler),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .PC_F            (PC_F),
    .instruction_D   (instruction_D),
    .PC_D            (PC_D),
    .valid_D         (valid_D)
  );

  int n_checks = 0;
  int n_err    = 0;

  // memory environment
  bit          mem_pend = 0;
  int          mem_cnt  = 0;
  logic [63:0] mem_addr = '0;
  int          lat      = 1;
  bit          rand_lat = 0;
  logic [63:0] req_log[$];
  bit          last_req;

  // reference model: outstanding / stale / held flags plus IF/ID contents
  logic [63:0] m_pc;
  bit          m_out, m_stale, m_held, m_iv;
  logic [31:0] m_hi, m_ii;
  logic [63:0] m_hp, m_ip;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0050_0093;
    if (a == 64'h4) return 32'h00A0_0113;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit br,
                       input logic [63:0] bt, input bit jh);
    bit          rv, redir, exp_req;
    logic [63:0] tgt, raddr;
    logic [31:0] rd;
    reset           = rst;
    stall_D         = st;
    branch_taken    = br;
    branch_target   = bt;
    jump_to_handler = jh;
    rv              = mem_pend && (mem_cnt == 1);
    rd              = rv ? mem_word(mem_addr) : 32'($urandom);
    imem_rvalid     = rv;
    imem_rdata      = rd;
    redir           = br | jh;
    tgt             = jh ? HPC : bt;
    exp_req         = !rst && !redir && !m_out && !m_held;
    #1;
    chk("imem_req", 64'(imem_req), 64'(exp_req));
    chk("PC_F", PC_F, m_pc);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    last_req = imem_req;
    raddr    = imem_addr;
    if (imem_req) req_log.push_back(imem_addr);
    @(posedge clk);
    if (rv) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (last_req) begin
      mem_pend = 1;
      mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      mem_addr = raddr;
    end
    if (rst || redir) begin
      m_out = m_out && !rv;
      if (m_out) m_stale = 1;
      m_held = 0;
      m_pc   = rst ? 64'h0 : tgt;
      m_ii   = NOP;
      m_ip   = '0;
      m_iv   = 0;
    end else if (exp_req) begin
      m_out   = 1;
      m_stale = 0;
    end else if (m_out && rv) begin
      m_out = 0;
      if (!m_stale) begin
        if (st) begin
          m_held = 1; m_hi = rd; m_hp = m_pc;
        end else begin
          m_ii = rd; m_ip = m_pc; m_iv = 1;
        end
        m_pc = m_pc + 64'd4;
      end
    end else if (m_held && !st) begin
      m_ii = m_hi; m_ip = m_hp; m_iv = 1; m_held = 0;
    end
    #1;
    chk("instruction_D", 64'(instruction_D), 64'(m_ii));
    chk("PC_D", PC_D, m_ip);
    chk("valid_D", 64'(valid_D), 64'(m_iv));
  endtask

  initial begin
    logic [63:0] bt;
    reset = 1; stall_D = 0; branch_taken = 0; jump_to_handler = 0;
    branch_target = '0; imem_rvalid = 0; imem_rdata = '0;
    @(posedge clk); #1;
    m_pc = '0; m_out = 0; m_stale = 0; m_held = 0; m_iv = 0;
    m_ii = NOP; m_ip = '0; m_hi = '0; m_hp = '0;

    cycle(1, 0, 0, 0, 0);
    chk("rst_instr", 64'(instruction_D), 64'(NOP));
    chk("rst_valid", 64'(valid_D), 64'h0);
    chk("rst_pcd", PC_D, 64'h0);
    chk("rst_pcf", PC_F, 64'h0);

    // back-to-back fetch, 1-cycle memory
    lat = 1;
    req_log.delete();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("first_instr", 64'(instruction_D), 64'h0050_0093);
    chk("first_pc", PC_D, 64'h0);
    chk("first_valid", 64'(valid_D), 64'h1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("second_instr", 64'(instruction_D), 64'h00A0_0113);
    chk("second_pc", PC_D, 64'h4);
    cycle(0, 0, 0, 0, 0);
    chk("addr_seq_len", 64'(req_log.size()), 64'd3);
    if (req_log.size() >= 3) begin
      chk("addr_seq0", req_log[0], 64'h0);
      chk("addr_seq1", req_log[1], 64'h4);
      chk("addr_seq2", req_log[2], 64'h8);
    end

    // response under stall goes to hold buffer
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("hold_noreq1", 64'(last_req), 64'h0);
    cycle(0, 1, 0, 0, 0);
    chk("hold_noreq2", 64'(last_req), 64'h0);
    chk("hold_stable", 64'(instruction_D), 64'h00A0_0113);
    cycle(0, 0, 0, 0, 0);
    chk("release_instr", 64'(instruction_D), 64'(mem_word(64'h8)));
    chk("release_pc", PC_D, 64'h8);

    // branch while waiting, 3-cycle memory
    lat = 3;
    cycle(0, 0, 0, 0, 0);
    chk("req_after_hold", req_log[$], 64'hC);
    cycle(0, 0, 1, 64'h40, 0);
    chk("br_pcf", PC_F, 64'h40);
    chk("br_flush", 64'(valid_D), 64'h0);
    cycle(0, 0, 0, 0, 0);
    chk("drop_noreq", 64'(last_req), 64'h0);
    cycle(0, 0, 0, 0, 0);
    chk("drop_valid", 64'(valid_D), 64'h0);
    lat = 1;
    cycle(0, 0, 0, 0, 0);
    chk("br_refetch", req_log[$], 64'h40);

    // handler overrides branch, coincident response discarded
    cycle(0, 0, 1, 64'h80, 1);
    chk("hdl_pcf", PC_F, HPC);
    chk("hdl_instr", 64'(instruction_D), 64'(NOP));
    chk("hdl_valid", 64'(valid_D), 64'h0);

    // redirect with response under stall
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("hdl_fetch_pc", PC_D, HPC);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 64'h200, 0);
    chk("flush_over_stall", 64'(valid_D), 64'h0);
    lat = 3;
    cycle(0, 0, 0, 0, 0);
    chk("stall_redir_fetch", req_log[$], 64'h200);

    // reset mid-WAIT, late response after release
    cycle(1, 0, 0, 0, 0);
    chk("midrst_pcf", PC_F, 64'h0);
    cycle(0, 0, 0, 0, 0);
    chk("midrst_noreq", 64'(last_req), 64'h0);
    cycle(0, 0, 0, 0, 0);
    chk("midrst_drop", 64'(valid_D), 64'h0);
    lat = 1;
    cycle(0, 0, 0, 0, 0);
    chk("midrst_fetch", req_log[$], 64'h0);
    cycle(0, 0, 0, 0, 0);
    chk("midrst_first", 64'(instruction_D), 64'h0050_0093);

    // randomized traffic
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) bt = 64'hFFFF_FFFF_FFFF_FFF8;
      else bt = {32'($urandom), 32'($urandom)} & ~64'h3;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 6, bt, $urandom_range(0, 99) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
